// File: rtl/fan_packet_decoder_if.sv
// Signal bundle between the fan remote serial line and its packet decoder.
// The line driver is the master; the decoder is the slave.
interface fan_packet_decoder_if;
  logic       in;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       frame_error;
  logic       busy;

  modport master (
    output in,
    input  cmd,
    input  cmd_valid,
    input  frame_error,
    input  busy
  );

  modport slave (
    input  in,
    output cmd,
    output cmd_valid,
    output frame_error,
    output busy
  );
endinterface

// File: rtl/fan_packet_decoder.sv
// Fan remote receiver: measures high/low run lengths on the synchronised line,
// rebuilds 13-symbol packets and maps the payload back to a 3-bit command.
module fan_packet_decoder #(
  parameter int unsigned UNIT_CYCLES = 2203,
  parameter int unsigned CTR_WIDTH   = 16,
  parameter logic [3:0]  ID          = 4'b1010,
  parameter int unsigned GAP_CYCLES  = 3 * UNIT_CYCLES
) (
  input logic                  ref_clk,
  input logic                  reset,
  fan_packet_decoder_if.slave  bus
);

  localparam int unsigned NumSymbols = 13;

  localparam logic [CTR_WIDTH-1:0] MinRun = CTR_WIDTH'(UNIT_CYCLES / 2);
  localparam logic [CTR_WIDTH-1:0] MidRun = CTR_WIDTH'((3 * UNIT_CYCLES) / 2);
  localparam logic [CTR_WIDTH-1:0] MaxRun = CTR_WIDTH'((5 * UNIT_CYCLES) / 2);
  localparam logic [CTR_WIDTH-1:0] GapRun = CTR_WIDTH'(GAP_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StHigh,
    StLow,
    StCheck,
    StRecover
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     sync_q;
  logic           s_dly_q;
  logic [CTR_WIDTH-1:0] cnt_q;
  logic [12:0]    bits_q, bits_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [2:0]     cmd_q, cmd_d;
  logic           cmd_valid_q, cmd_valid_d;
  logic           frame_error_q, frame_error_d;

  logic s;
  logic rise;
  logic fall;
  logic high_err;
  logic high_bit;
  logic low_ok;
  logic gap_reached;
  logic header_ok;
  logic payload_ok;
  logic [2:0] payload_cmd;

  assign s    = sync_q[1];
  assign rise = s & ~s_dly_q;
  assign fall = ~s & s_dly_q;

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      sync_q  <= 2'b00;
      s_dly_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], bus.in};
      s_dly_q <= sync_q[1];
    end
  end

  // At an edge cnt_q still holds the length of the run that just ended.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (rise || fall) begin
      cnt_q <= CTR_WIDTH'(1);
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + CTR_WIDTH'(1);
    end
  end

  assign high_err    = (cnt_q < MinRun) || (cnt_q > MaxRun);
  assign high_bit    = (cnt_q >= MidRun);
  assign low_ok      = (cnt_q >= MinRun) && (cnt_q <= MaxRun);
  assign gap_reached = (cnt_q >= GapRun);
  assign header_ok   = (bits_q[1:0] == 2'b00) && (bits_q[5:2] == ID);

  always_comb begin
    payload_ok  = 1'b1;
    payload_cmd = 3'd0;
    case (bits_q[12:6])
      7'b1001111: payload_cmd = 3'd0;
      7'b1000111: payload_cmd = 3'd1;
      7'b0100111: payload_cmd = 3'd2;
      7'b0010111: payload_cmd = 3'd3;
      7'b0001111: payload_cmd = 3'd4;
      default:    payload_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    bits_d        = bits_q;
    bit_cnt_d     = bit_cnt_q;
    cmd_d         = cmd_q;
    cmd_valid_d   = 1'b0;
    frame_error_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (rise) begin
          bits_d    = '0;
          bit_cnt_d = '0;
          state_d   = StHigh;
        end
      end
      StHigh: begin
        if (fall) begin
          if (high_err) begin
            frame_error_d = 1'b1;
            state_d       = StRecover;
          end else begin
            for (int unsigned i = 0; i < NumSymbols; i++) begin
              if (bit_cnt_q == 4'(i)) bits_d[i] = high_bit;
            end
            bit_cnt_d = bit_cnt_q + 4'd1;
            state_d   = StLow;
          end
        end
      end
      StLow: begin
        if (rise) begin
          if ((bit_cnt_q == 4'(NumSymbols)) || !low_ok) begin
            frame_error_d = 1'b1;
            state_d       = StRecover;
          end else begin
            state_d = StHigh;
          end
        end else if (gap_reached) begin
          if (bit_cnt_q == 4'(NumSymbols)) begin
            state_d = StCheck;
          end else begin
            frame_error_d = 1'b1;
            state_d       = StRecover;
          end
        end
      end
      StCheck: begin
        if (header_ok && payload_ok) begin
          cmd_d       = payload_cmd;
          cmd_valid_d = 1'b1;
        end else begin
          frame_error_d = 1'b1;
        end
        state_d = StIdle;
      end
      StRecover: begin
        // On a falling edge the counter still holds the high run, so skip it.
        if (!s && !fall && gap_reached) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state_q       <= StIdle;
      bits_q        <= '0;
      bit_cnt_q     <= '0;
      cmd_q         <= '0;
      cmd_valid_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bits_q        <= bits_d;
      bit_cnt_q     <= bit_cnt_d;
      cmd_q         <= cmd_d;
      cmd_valid_q   <= cmd_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign bus.cmd         = cmd_q;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.frame_error = frame_error_q;
  assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_fan_packet_decoder.sv
// Bench for fan_packet_decoder: directed and randomised packets described as
// run lengths, with outcomes predicted from the line-coding rules.
module tb_fan_packet_decoder;

  localparam int U       = 20;
  localparam int MIN_RUN = U / 2;
  localparam int MID_RUN = 3 * U / 2;
  localparam int MAX_RUN = 5 * U / 2;
  localparam int GAP     = 3 * U;

  logic ref_clk = 1'b0;
  logic reset   = 1'b1;

  fan_packet_decoder_if bus ();

  fan_packet_decoder #(.UNIT_CYCLES(U)) dut (
    .ref_clk(ref_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 ref_clk = ~ref_clk;

  logic [6:0] codes [5] = '{7'b1001111, 7'b1000111, 7'b0100111, 7'b0010111, 7'b0001111};
  int hi_bounds [6] = '{9, 10, 29, 30, 50, 51};
  int lo_bounds [4] = '{9, 10, 50, 51};

  int   cyc = 0;
  int   n_cv = 0, n_fe = 0, n_viol = 0, cv_cyc = 0;
  logic prev_cv = 1'b0, prev_fe = 1'b0;
  int   n_checks = 0, n_err = 0;
  int   lo_q[$], hi_q[$];
  int   rst_at = -1;
  int   fall_cyc = 0;
  int   model_cmd = 0;

  always @(posedge ref_clk) cyc <= cyc + 1;

  always @(negedge ref_clk) begin
    if (bus.cmd_valid) begin
      n_cv   <= n_cv + 1;
      cv_cyc <= cyc;
    end
    if (bus.frame_error) n_fe <= n_fe + 1;
    if ((bus.cmd_valid && bus.frame_error) || (bus.cmd_valid && prev_cv) ||
        (bus.frame_error && prev_fe)) n_viol <= n_viol + 1;
    prev_cv <= bus.cmd_valid;
    prev_fe <= bus.frame_error;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    bus.in = v;
    repeat (n) @(posedge ref_clk);
    #1;
  endtask

  // Nominal symbol timing: bit0 = 2U low / 1U high, bit1 = 1U low / 2U high.
  task automatic build(input logic [12:0] bits, input int nsym, input bit jitter);
    lo_q.delete();
    hi_q.delete();
    for (int i = 0; i < nsym; i++) begin
      logic b;
      int   lo, hi;
      b  = (i < 13) ? bits[i] : 1'b0;
      lo = b ? U : 2 * U;
      hi = b ? 2 * U : U;
      if (jitter) begin
        lo += int'($urandom_range(0, 6)) - 3;
        hi += int'($urandom_range(0, 6)) - 3;
      end
      lo_q.push_back(lo);
      hi_q.push_back(hi);
    end
  endtask

  task automatic send_pkt();
    for (int i = 0; i < hi_q.size(); i++) begin
      hold(1'b0, lo_q[i]);
      if (i == rst_at) begin
        bus.in = 1'b1;
        reset  = 1'b1;
        @(posedge ref_clk);
        #1;
        reset = 1'b0;
        chk("mid_reset.cmd", int'(bus.cmd), 0);
        chk("mid_reset.cmd_valid", int'(bus.cmd_valid), 0);
        chk("mid_reset.frame_error", int'(bus.frame_error), 0);
        chk("mid_reset.busy", int'(bus.busy), 0);
        hold(1'b1, hi_q[i] - 1);
      end else begin
        hold(1'b1, hi_q[i]);
      end
    end
    fall_cyc = cyc;
    hold(1'b0, GAP + 12);
  endtask

  // kind: 1 = decoded command c, 2 = frame error.
  function automatic void predict(output int kind, output int c);
    logic [12:0] bits;
    int n;
    bits = '0;
    n    = hi_q.size();
    kind = 2;
    c    = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && (i >= 13 || lo_q[i] < MIN_RUN || lo_q[i] > MAX_RUN)) return;
      if (hi_q[i] < MIN_RUN || hi_q[i] > MAX_RUN) return;
      bits[i] = (hi_q[i] >= MID_RUN);
    end
    if (n != 13) return;
    if (bits[1:0] != 2'b00 || bits[5:2] != 4'b1010) return;
    for (int k = 0; k < 5; k++) begin
      if (bits[12:6] == codes[k]) begin
        kind = 1;
        c    = k;
      end
    end
  endfunction

  task automatic run_pkt(input string tag);
    int cv0, fe0, kind, c;
    cv0 = n_cv;
    fe0 = n_fe;
    send_pkt();
    predict(kind, c);
    if (kind == 1) model_cmd = c;
    chk({tag, ".cmd_valid_pulses"}, n_cv - cv0, (kind == 1) ? 1 : 0);
    chk({tag, ".frame_error_pulses"}, n_fe - fe0, (kind == 2) ? 1 : 0);
    chk({tag, ".cmd"}, int'(bus.cmd), model_cmd);
    chk({tag, ".busy"}, int'(bus.busy), 0);
    if (kind == 1) chk({tag, ".latency"}, cv_cyc - fall_cyc, GAP + 4);
  endtask

  function automatic logic [12:0] pkt_bits(input logic [6:0] p, input logic [3:0] id);
    return {p, id, 2'b00};
  endfunction

  initial begin
    int cv0;
    bus.in = 1'b0;
    reset  = 1'b1;
    repeat (3) @(posedge ref_clk);
    #1;
    chk("reset.cmd", int'(bus.cmd), 0);
    chk("reset.cmd_valid", int'(bus.cmd_valid), 0);
    chk("reset.frame_error", int'(bus.frame_error), 0);
    chk("reset.busy", int'(bus.busy), 0);
    reset = 1'b0;
    hold(1'b0, 10);

    build(pkt_bits(codes[2], 4'b1010), 13, 1'b0);
    run_pkt("ideal_cmd2");

    build(pkt_bits(codes[0], 4'b1010), 13, 1'b0); run_pkt("b2b_cmd0");
    build(pkt_bits(codes[4], 4'b1010), 13, 1'b0); run_pkt("b2b_cmd4");
    build(pkt_bits(codes[1], 4'b1010), 13, 1'b0); run_pkt("b2b_cmd1");
    build(pkt_bits(codes[3], 4'b1010), 13, 1'b0); run_pkt("b2b_cmd3");

    build(pkt_bits(codes[2], 4'b0110), 13, 1'b0);
    run_pkt("bad_id");

    build(pkt_bits(codes[4], 4'b1010), 7, 1'b0);
    hi_q[6] = 5;
    run_pkt("short_high");
    build(pkt_bits(codes[1], 4'b1010), 13, 1'b0);
    run_pkt("after_recover_cmd1");

    build(pkt_bits(codes[0], 4'b1010), 10, 1'b0);
    run_pkt("truncated");
    build(pkt_bits(codes[0], 4'b1010), 14, 1'b0);
    run_pkt("extra_symbol");

    // Every high and low run sits exactly on a classification boundary.
    build(pkt_bits(codes[3], 4'b1010), 13, 1'b0);
    for (int i = 0; i < 13; i++) begin
      if (hi_q[i] < MID_RUN) hi_q[i] = (i % 2) ? MID_RUN - 1 : MIN_RUN;
      else                   hi_q[i] = (i % 2) ? MAX_RUN : MID_RUN;
      if (i > 0) lo_q[i] = (i % 2) ? MAX_RUN : MIN_RUN;
    end
    run_pkt("boundary_ok");
    build(pkt_bits(codes[3], 4'b1010), 13, 1'b0);
    hi_q[4] = MAX_RUN + 1;
    run_pkt("high_over_max");
    build(pkt_bits(codes[3], 4'b1010), 13, 1'b0);
    lo_q[5] = MIN_RUN - 1;
    run_pkt("low_too_short");

    lo_q.delete(); hi_q.delete();
    lo_q.push_back(U);
    hi_q.push_back(200);
    run_pkt("stuck_high");

    build(pkt_bits(codes[2], 4'b1010), 13, 1'b0);
    rst_at = 7;
    cv0 = n_cv;
    send_pkt();
    rst_at = -1;
    model_cmd = 0;
    chk("reset_pkt.cmd_valid_pulses", n_cv - cv0, 0);
    chk("reset_pkt.cmd", int'(bus.cmd), 0);
    chk("reset_pkt.busy", int'(bus.busy), 0);
    build(pkt_bits(codes[4], 4'b1010), 13, 1'b0);
    run_pkt("after_reset_cmd4");

    for (int n = 0; n < 40; n++) begin
      int r, nsym;
      logic [6:0] p;
      logic [3:0] id;
      logic [12:0] bits;
      r    = int'($urandom_range(0, 9));
      p    = codes[$urandom_range(0, 4)];
      id   = 4'b1010;
      nsym = 13;
      if (r == 0) id = 4'($urandom_range(0, 15));
      if (r == 1) p = 7'($urandom_range(0, 127));
      if (r == 5) nsym = int'($urandom_range(1, 12));
      if (r == 6) nsym = 14;
      bits = pkt_bits(p, id);
      if (r == 2) bits[0] = 1'b1;
      build(bits, nsym, 1'b1);
      if (r == 3) hi_q[$urandom_range(0, 12)] = hi_bounds[$urandom_range(0, 5)];
      if (r == 4) lo_q[$urandom_range(1, 12)] = lo_bounds[$urandom_range(0, 3)];
      run_pkt($sformatf("random%0d", n));
    end

    chk("pulse_rules", n_viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
